tag_cache_acq_arbiter: RTL and testbench

Shares the single uncached TileLink acquire/grant port of the tag cache among NCORE requesters. Arbitrates acquires round-robin and keeps multi-beat puts atomic. Stamps each forwarded acquire with the requester index as client_id, and routes grants back to their requester by client_id. Also limits outstanding transactions per requester.

---
 rtl/cache_pkg.sv | 37 +++
 rtl/tag_cache_rr_pick.sv | 42 ++++
 rtl/tag_cache_acq_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_tag_cache_acq_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared tag cache encodings, widths and arbiter state type
// Purpose: common constants and types for the tag cache acquire arbiter.
// Ports: none (package).
package cache_pkg;

  // Field-width defaults for the uncached acquire/grant port.
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int XACT_W_DEF = 4;
  localparam int TYPE_W_DEF = 3;

  // Outstanding counters are wide enough for MAX_OUT up to 15.
  localparam int OCNT_W = 4;

  // Acquire type encodings.
  localparam logic [TYPE_W_DEF-1:0] ACQ_GET       = 3'd0;
  localparam logic [TYPE_W_DEF-1:0] ACQ_GET_BLOCK = 3'd1;
  localparam logic [TYPE_W_DEF-1:0] ACQ_PUT       = 3'd2;
  localparam logic [TYPE_W_DEF-1:0] ACQ_PUT_BLOCK = 3'd3;

  // Grant type encodings.
  localparam logic [TYPE_W_DEF-1:0] GNT_PUT_ACK    = 3'd0;
  localparam logic [TYPE_W_DEF-1:0] GNT_GET_DATA   = 3'd1;
  localparam logic [TYPE_W_DEF-1:0] GNT_BLOCK_DATA = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BURST = 2'd2
  } arb_state_e;

  // Client id width: at least one bit even with a single requester.
  function automatic int cid_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tag_cache_rr_pick.sv
// rtl/tag_cache_rr_pick.sv - combinational round-robin priority picker
// Purpose: pick the first eligible requester scanning rr_ptr, rr_ptr+1, ... mod NCORE.
// Ports:
//   eligible  - per-requester eligibility
//   rr_ptr    - index with highest priority this cycle (always < NCORE)
//   sel       - chosen index (0 when nothing is eligible)
//   any_valid - at least one requester is eligible
module tag_cache_rr_pick #(
  parameter int NCORE = 2,
  parameter int CID_W = 1
) (
  input  logic [NCORE-1:0] eligible,
  input  logic [CID_W-1:0] rr_ptr,
  output logic [CID_W-1:0] sel,
  output logic             any_valid
);

  // Rotate so that bit k corresponds to requester (rr_ptr + k) mod NCORE.
  logic [NCORE-1:0] rotated;
  logic [CID_W-1:0] idx [NCORE];

  assign rotated = NCORE'({eligible, eligible} >> rr_ptr);

  for (genvar k = 0; k < NCORE; k++) begin : g_idx
    logic [CID_W:0] sum;
    assign sum    = {1'b0, rr_ptr} + (CID_W+1)'(k);
    assign idx[k] = CID_W'((sum >= (CID_W+1)'(NCORE)) ? (sum - (CID_W+1)'(NCORE)) : sum);
  end

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    for (int k = NCORE - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        sel       = idx[k];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tag_cache_acq_arbiter.sv
// rtl/tag_cache_acq_arbiter.sv - round-robin acquire arbiter and grant router for the tag cache
// Purpose: share one uncached acquire/grant port among NCORE requesters, keeping
//   multi-beat puts atomic, stamping client_id, routing grants by client_id and
//   limiting outstanding transactions per requester.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   req_acq_*           - per-requester acquire channel (flattened fields)
//   acq_*               - muxed acquire channel to the tag cache, plus acq_client_id
//   gnt_*               - grant channel from the tag cache
//   req_gnt_*           - demuxed grant valid / per-requester ready, broadcast fields
//   err_bad_gnt         - sticky flag: bad client_id grant or grant counter underflow
module tag_cache_acq_arbiter
  import cache_pkg::*;
#(
  parameter int NCORE   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int XACT_W  = 4,
  parameter int TYPE_W  = 3,
  parameter int BEATS   = 8,
  parameter int MAX_OUT = 4,
  localparam int CID_W  = cid_width(NCORE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORE-1:0]         req_acq_valid,
  output logic [NCORE-1:0]         req_acq_ready,
  input  logic [NCORE*ADDR_W-1:0]  req_acq_addr,
  input  logic [NCORE*DATA_W-1:0]  req_acq_data,
  input  logic [NCORE*TYPE_W-1:0]  req_acq_type,
  input  logic [NCORE*XACT_W-1:0]  req_acq_xact_id,
  input  logic [NCORE-1:0]         req_acq_multibeat,
  output logic                     acq_valid,
  input  logic                     acq_ready,
  output logic [ADDR_W-1:0]        acq_addr,
  output logic [DATA_W-1:0]        acq_data,
  output logic [TYPE_W-1:0]        acq_type,
  output logic [XACT_W-1:0]        acq_xact_id,
  output logic [CID_W-1:0]         acq_client_id,
  input  logic                     gnt_valid,
  output logic                     gnt_ready,
  input  logic [CID_W-1:0]         gnt_client_id,
  input  logic [XACT_W-1:0]        gnt_xact_id,
  input  logic [TYPE_W-1:0]        gnt_type,
  input  logic [DATA_W-1:0]        gnt_data,
  input  logic                     gnt_last,
  output logic [NCORE-1:0]         req_gnt_valid,
  input  logic [NCORE-1:0]         req_gnt_ready,
  output logic [XACT_W-1:0]        req_gnt_xact_id,
  output logic [TYPE_W-1:0]        req_gnt_type,
  output logic [DATA_W-1:0]        req_gnt_data,
  output logic                     err_bad_gnt
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CID_W-1:0]  LAST_CID  = CID_W'(NCORE - 1);

  arb_state_e        state, state_nxt;
  logic [CID_W-1:0]  rr_ptr, rr_nxt;
  logic [CID_W-1:0]  owner, owner_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic [OCNT_W-1:0] out_cnt [NCORE];
  logic [OCNT_W-1:0] cnt_nxt [NCORE];
  logic              err_q;

  logic [NCORE-1:0]  eligible;
  logic [NCORE-1:0]  inc_v, dec_v;
  logic [CID_W-1:0]  sel, fwd;
  logic              any_elig, fwd_valid, acq_fire, first_beat;
  logic              gnt_bad, gnt_done, underflow;

  logic [ADDR_W-1:0] addr_a [NCORE];
  logic [DATA_W-1:0] data_a [NCORE];
  logic [TYPE_W-1:0] type_a [NCORE];
  logic [XACT_W-1:0] xact_a [NCORE];

  function automatic logic [CID_W-1:0] next_idx(input logic [CID_W-1:0] x);
    return (x == LAST_CID) ? '0 : x + 1'b1;
  endfunction

  for (genvar i = 0; i < NCORE; i++) begin : g_req
    assign addr_a[i]   = req_acq_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i]   = req_acq_data[i*DATA_W +: DATA_W];
    assign type_a[i]   = req_acq_type[i*TYPE_W +: TYPE_W];
    assign xact_a[i]   = req_acq_xact_id[i*XACT_W +: XACT_W];
    assign eligible[i] = req_acq_valid[i] && (out_cnt[i] < OCNT_W'(MAX_OUT));
    assign inc_v[i]    = acq_fire && first_beat && (fwd == CID_W'(i));
    assign dec_v[i]    = gnt_done && (gnt_client_id == CID_W'(i));
  end

  tag_cache_rr_pick #(
    .NCORE (NCORE),
    .CID_W (CID_W)
  ) u_rr_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .sel       (sel),
    .any_valid (any_elig)
  );

  // Outside IDLE the owner is locked in; its out_cnt is not re-checked.
  assign fwd        = (state == IDLE) ? sel : owner;
  assign fwd_valid  = (state == IDLE) ? any_elig : req_acq_valid[owner];
  assign first_beat = (state != BURST);

  assign acq_valid     = reset && fwd_valid;
  assign acq_addr      = addr_a[fwd];
  assign acq_data      = data_a[fwd];
  assign acq_type      = type_a[fwd];
  assign acq_xact_id   = xact_a[fwd];
  assign acq_client_id = fwd;
  assign acq_fire      = acq_valid && acq_ready;

  always_comb begin
    req_acq_ready = '0;
    if (reset && ((state != IDLE) || any_elig)) begin
      req_acq_ready[fwd] = acq_ready;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE, HOLD: begin
        if (acq_fire) begin
          if (req_acq_multibeat[fwd]) begin
            owner_nxt = fwd;
            beat_nxt  = BEAT_W'(1);
            state_nxt = BURST;
          end else begin
            rr_nxt    = next_idx(fwd);
            state_nxt = IDLE;
          end
        end else if (fwd_valid) begin
          owner_nxt = fwd;
          state_nxt = HOLD;
        end
      end
      BURST: begin
        if (acq_fire) begin
          if (beat_cnt == LAST_BEAT) begin
            rr_nxt    = next_idx(owner);
            beat_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grants addressed beyond NCORE are accepted and dropped.
  assign gnt_bad = (int'(gnt_client_id) >= NCORE);

  always_comb begin
    req_gnt_valid = '0;
    gnt_ready     = 1'b0;
    if (reset) begin
      if (gnt_bad) begin
        gnt_ready = 1'b1;
      end else begin
        req_gnt_valid[gnt_client_id] = gnt_valid;
        gnt_ready                    = req_gnt_ready[gnt_client_id];
      end
    end
  end

  assign req_gnt_xact_id = gnt_xact_id;
  assign req_gnt_type    = gnt_type;
  assign req_gnt_data    = gnt_data;
  assign gnt_done        = gnt_valid && gnt_ready && !gnt_bad && gnt_last;

  // Simultaneous issue and completion for a requester leave its count unchanged.
  always_comb begin
    underflow = 1'b0;
    for (int i = 0; i < NCORE; i++) begin
      cnt_nxt[i] = out_cnt[i];
      if (inc_v[i] && !dec_v[i]) begin
        cnt_nxt[i] = out_cnt[i] + 1'b1;
      end else if (dec_v[i] && !inc_v[i]) begin
        if (out_cnt[i] == '0) begin
          underflow = 1'b1;
        end else begin
          cnt_nxt[i] = out_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NCORE; i++) begin
        out_cnt[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_nxt;
      err_q    <= err_q | (gnt_valid & gnt_bad) | underflow;
      for (int i = 0; i < NCORE; i++) begin
        out_cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign err_bad_gnt = err_q;

endmodule

// File: tb/tb_tag_cache_acq_arbiter.sv
// tb/tb_tag_cache_acq_arbiter.sv - self-checking bench for tag_cache_acq_arbiter
module tb_tag_cache_acq_arbiter;
  localparam int N     = 3;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int XW    = 4;
  localparam int TW    = 3;
  localparam int BEATS = 8;
  localparam int MAXO  = 4;
  localparam int CW    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_acq_valid, req_acq_ready, req_acq_multibeat;
  logic [N*AW-1:0] req_acq_addr;
  logic [N*DW-1:0] req_acq_data;
  logic [N*TW-1:0] req_acq_type;
  logic [N*XW-1:0] req_acq_xact_id;
  logic            acq_valid, acq_ready;
  logic [AW-1:0]   acq_addr;
  logic [DW-1:0]   acq_data;
  logic [TW-1:0]   acq_type;
  logic [XW-1:0]   acq_xact_id;
  logic [CW-1:0]   acq_client_id;
  logic            gnt_valid, gnt_ready, gnt_last;
  logic [CW-1:0]   gnt_client_id;
  logic [XW-1:0]   gnt_xact_id, req_gnt_xact_id;
  logic [TW-1:0]   gnt_type, req_gnt_type;
  logic [DW-1:0]   gnt_data, req_gnt_data;
  logic [N-1:0]    req_gnt_valid, req_gnt_ready;
  logic            err_bad_gnt;

  always #5 clk = ~clk;

  tag_cache_acq_arbiter #(
    .NCORE(N), .ADDR_W(AW), .DATA_W(DW), .XACT_W(XW), .TYPE_W(TW),
    .BEATS(BEATS), .MAX_OUT(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_acq_valid(req_acq_valid), .req_acq_ready(req_acq_ready),
    .req_acq_addr(req_acq_addr), .req_acq_data(req_acq_data),
    .req_acq_type(req_acq_type), .req_acq_xact_id(req_acq_xact_id),
    .req_acq_multibeat(req_acq_multibeat),
    .acq_valid(acq_valid), .acq_ready(acq_ready), .acq_addr(acq_addr),
    .acq_data(acq_data), .acq_type(acq_type), .acq_xact_id(acq_xact_id),
    .acq_client_id(acq_client_id),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt_client_id(gnt_client_id),
    .gnt_xact_id(gnt_xact_id), .gnt_type(gnt_type), .gnt_data(gnt_data),
    .gnt_last(gnt_last),
    .req_gnt_valid(req_gnt_valid), .req_gnt_ready(req_gnt_ready),
    .req_gnt_xact_id(req_gnt_xact_id), .req_gnt_type(req_gnt_type),
    .req_gnt_data(req_gnt_data), .err_bad_gnt(err_bad_gnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: lock = -1 means no requester owns the port.
  int m_rr, m_lock, m_beat;
  bit m_burst, m_err;
  int m_cnt [N];

  // Requester-side stimulus state.
  bit          pend [N];
  bit          mb   [N];
  int          left [N];
  logic [AW-1:0] r_addr [N];
  logic [TW-1:0] r_type [N];
  logic [XW-1:0] r_xact [N];

  // DUT observations captured at the sample point of the last tick.
  bit           obs_fire;
  int           obs_cid;
  logic [N-1:0] obs_rdy;
  bit           obs_gr;
  logic [N-1:0] obs_gv;
  bit           obs_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_txn(input int i, input bit multi);
    pend[i]   = 1'b1;
    mb[i]     = multi;
    left[i]   = multi ? BEATS : 1;
    r_addr[i] = $urandom;
    r_type[i] = TW'($urandom_range(0, 7));
    r_xact[i] = XW'($urandom_range(0, 15));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_acq_valid[i]            = pend[i];
      req_acq_multibeat[i]        = mb[i];
      req_acq_addr[i*AW +: AW]    = r_addr[i];
      req_acq_type[i*TW +: TW]    = r_type[i];
      req_acq_xact_id[i*XW +: XW] = r_xact[i];
      req_acq_data[i*DW +: DW]    = {$urandom, $urandom};
    end
  endtask

  task automatic set_gnt(input bit v, input int c, input bit last);
    gnt_valid     = v;
    gnt_client_id = CW'(c);
    gnt_last      = last;
    gnt_xact_id   = XW'($urandom_range(0, 15));
    gnt_type      = TW'($urandom_range(0, 7));
    gnt_data      = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    m_rr = 0; m_lock = -1; m_beat = 0; m_burst = 0; m_err = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      pend[i]  = 0;
      mb[i]    = 0;
      left[i]  = 0;
    end
  endtask

  // Entered at posedge+1; samples at the falling edge, advances the model,
  // returns at the next posedge+1.
  task automatic tick();
    int sel, cid;
    bit v, bad, egr, inc, dec, hs;
    logic [N-1:0] er, egv;
    #4;
    sel = 0;
    v   = 0;
    if (m_lock < 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        int i;
        i = (m_rr + k) % N;
        if (req_acq_valid[i] && m_cnt[i] < MAXO) begin
          sel = i;
          v   = 1;
        end
      end
    end else begin
      sel = m_lock;
      v   = req_acq_valid[sel];
    end
    er = (m_lock >= 0 || v) ? (N'(acq_ready) << sel) : '0;

    obs_fire = acq_valid && acq_ready;
    obs_cid  = int'(acq_client_id);
    obs_rdy  = req_acq_ready;
    obs_gr   = gnt_ready;
    obs_gv   = req_gnt_valid;
    obs_err  = err_bad_gnt;

    chk("acq_valid", acq_valid, v);
    chk("req_acq_ready", req_acq_ready, er);
    if (v) begin
      chk("acq_client_id", acq_client_id, sel);
      chk("acq_addr", acq_addr, req_acq_addr[sel*AW +: AW]);
      chk("acq_data", acq_data, req_acq_data[sel*DW +: DW]);
      chk("acq_type", acq_type, req_acq_type[sel*TW +: TW]);
      chk("acq_xact_id", acq_xact_id, req_acq_xact_id[sel*XW +: XW]);
    end

    cid = int'(gnt_client_id);
    bad = (cid >= N);
    egr = bad ? 1'b1 : req_gnt_ready[cid];
    egv = (bad || !gnt_valid) ? '0 : (N'(1) << cid);
    chk("gnt_ready", gnt_ready, egr);
    chk("req_gnt_valid", req_gnt_valid, egv);
    chk("req_gnt_data", req_gnt_data, gnt_data);
    chk("err_bad_gnt", err_bad_gnt, m_err);

    hs = v && acq_ready;
    if (gnt_valid && bad) m_err = 1;
    for (int i = 0; i < N; i++) begin
      inc = hs && !m_burst && (i == sel);
      dec = gnt_valid && !bad && egr && gnt_last && (i == cid);
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err = 1;
        else m_cnt[i]--;
      end
    end

    if (!m_burst) begin
      if (hs) begin
        if (req_acq_multibeat[sel]) begin
          m_burst = 1; m_lock = sel; m_beat = 1;
        end else begin
          m_lock = -1; m_rr = (sel + 1) % N;
        end
      end else if (v) begin
        m_lock = sel;
      end
    end else if (hs) begin
      m_beat++;
      if (m_beat == BEATS) begin
        m_burst = 0; m_lock = -1; m_beat = 0; m_rr = (sel + 1) % N;
      end
    end

    if (hs) begin
      left[sel]--;
      if (left[sel] == 0) pend[sel] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    drive_reqs();
    tick();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_acq_valid", acq_valid, 1'b0);
    chk("rst_req_acq_ready", req_acq_ready, '0);
    chk("rst_gnt_ready", gnt_ready, 1'b0);
    chk("rst_req_gnt_valid", req_gnt_valid, '0);
    chk("rst_err", err_bad_gnt, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    set_gnt(0, 0, 0);
    req_gnt_ready = '1;
    for (int c = 0; c < N; c++) begin
      for (int t = 0; t < 20 && m_cnt[c] > 0; t++) begin
        set_gnt(1, c, 1);
        step();
      end
    end
    set_gnt(0, 0, 0);
  endtask

  task automatic rand_cycle(input bit allow_new);
    int c;
    for (int i = 0; i < N; i++) begin
      if (allow_new && !pend[i] && $urandom_range(0, 3) == 0)
        new_txn(i, $urandom_range(0, 4) == 0);
    end
    acq_ready = ($urandom_range(0, 3) != 0);
    c = $urandom_range(0, N - 1);
    set_gnt(m_cnt[c] > 0 && $urandom_range(0, 1) == 1, c, $urandom_range(0, 2) != 0);
    req_gnt_ready = N'($urandom);
    step();
  endtask

  initial begin
    int nb;
    bit busy;
    reset = 1'b0;
    acq_ready = 1'b0;
    req_gnt_ready = '0;
    model_reset();
    set_gnt(0, 0, 0);
    drive_reqs();
    @(posedge clk);
    #1;

    // Reset with activity on every input.
    for (int i = 0; i < N; i++) new_txn(i, 0);
    drive_reqs();
    acq_ready = 1'b1;
    set_gnt(1, 0, 1);
    req_gnt_ready = '1;
    apply_reset();
    set_gnt(0, 0, 0);

    // Lone requester 1: forwarded in the same cycle with client_id 1.
    acq_ready = 1'b1;
    new_txn(1, 0);
    step();
    chk("single_fire", obs_fire, 1'b1);
    chk("single_cid", obs_cid, 1);

    // Two requesters always valid alternate.
    for (int t = 0; t < 4; t++) begin
      if (!pend[0]) new_txn(0, 0);
      if (!pend[1]) new_txn(1, 0);
      step();
      chk("alt_fire", obs_fire, 1'b1);
      chk("alt_owner", obs_cid, t % 2);
    end

    // Choice is held while the cache stalls even when another requester appears.
    new_txn(0, 0);
    acq_ready = 1'b0;
    step();
    new_txn(1, 0);
    for (int t = 0; t < 2; t++) begin
      step();
      chk("hold_cid", obs_cid, 0);
    end
    acq_ready = 1'b1;
    step();
    chk("hold_hs_fire", obs_fire, 1'b1);
    chk("hold_hs_cid", obs_cid, 0);
    step();
    chk("hold_next_cid", obs_cid, 1);
    drain();

    // Multi-beat put stays contiguous under a toggling ready.
    new_txn(0, 1);
    new_txn(1, 0);
    nb = 0;
    for (int t = 0; t < 40 && pend[0]; t++) begin
      acq_ready = (t % 2 == 0);
      step();
      if (obs_fire && obs_cid == 0) nb++;
      chk("burst_rdy1", obs_rdy[1], 1'b0);
    end
    chk("burst_beats", nb, BEATS);
    acq_ready = 1'b1;
    step();
    chk("after_burst_fire", obs_fire, 1'b1);
    chk("after_burst_cid", obs_cid, 1);
    drain();

    // Outstanding limit: fifth acquire waits for a final grant beat.
    acq_ready = 1'b1;
    for (int t = 0; t < MAXO; t++) begin
      new_txn(0, 0);
      step();
      chk("maxout_fill", obs_fire, 1'b1);
    end
    new_txn(0, 0);
    step();
    chk("maxout_block", obs_fire, 1'b0);
    chk("maxout_rdy", obs_rdy[0], 1'b0);
    set_gnt(1, 0, 1);
    req_gnt_ready = '1;
    step();
    chk("maxout_same_cycle", obs_fire, 1'b0);
    set_gnt(0, 0, 0);
    step();
    chk("maxout_release", obs_fire, 1'b1);
    drain();

    // Randomized traffic.
    for (int t = 0; t < 1500; t++) rand_cycle(1);
    busy = 1;
    for (int t = 0; t < 2000 && busy; t++) begin
      busy = 0;
      for (int i = 0; i < N; i++) if (pend[i]) busy = 1;
      if (busy) rand_cycle(0);
    end
    chk("flush_timeout", busy, 1'b0);
    drain();

    // Grant to a nonexistent client is dropped and flagged.
    set_gnt(1, 3, 1);
    req_gnt_ready = '0;
    step();
    chk("bad_gnt_ready", obs_gr, 1'b1);
    chk("bad_gnt_valid", obs_gv, '0);
    set_gnt(0, 0, 0);
    step();
    chk("bad_gnt_err", obs_err, 1'b1);

    // Reset in the middle of a burst.
    new_txn(0, 1);
    acq_ready = 1'b1;
    for (int t = 0; t < 3; t++) step();
    set_gnt(1, 0, 1);
    req_gnt_ready = '1;
    drive_reqs();
    req_acq_valid = '1;
    apply_reset();
    set_gnt(0, 0, 0);
    for (int t = 0; t < 100; t++) rand_cycle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
